vga_pixel_fetch: RTL and testbench

- Memory-side read client for the VGA output stage.
- On each VGA fetch request, it turns the display stage's registered hcount/vcount into a ZBT word address in the currently displayed frame bank, then issues one read through the shared-memory arbiter.
- It returns the 36-bit word (two packed 18-bit YCrCb pixels) on vga_pixel and pulses done_vga.
- It also owns double-buffer bank selection: bank swaps take effect only at frame start, so the display never tears.

---
 rtl/vga_pixel_fetch_if.sv | 23 ++
 rtl/vga_pixel_fetch.sv | 149 ++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_fetch_if.sv
// rtl/vga_pixel_fetch_if.sv - read port between the VGA fetch client and the shared-memory arbiter
interface vga_pixel_fetch_if #(
  parameter int LOG_ADDR = 19
) ();
  logic                mem_req;
  logic [LOG_ADDR-1:0] mem_addr;
  logic                mem_grant;
  logic [35:0]         mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_grant,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_grant,
    output mem_rdata
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - VGA pixel-pair read client with tear-free double-buffer bank swap
// Optional stall/overrun statistics ports are enabled by defining VGA_FETCH_STATS_EN.
module vga_pixel_fetch #(
  parameter int LOG_ADDR   = 19,
  parameter int MEM_LAT    = 2,
  parameter int HACTIVE    = 640,
  parameter int VACTIVE    = 480,
  parameter int BANK1_BASE = 153600
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_flag,
  input  logic                vga_flag,
  input  logic [9:0]          clocked_hcount,
  input  logic [9:0]          clocked_vcount,
  vga_pixel_fetch_if.master   mem,
  output logic [35:0]         vga_pixel,
  output logic                done_vga,
  output logic                disp_bank,
`ifdef VGA_FETCH_STATS_EN
  output logic [15:0]         stall_cycles,
  output logic [7:0]          overrun_count,
`endif
  output logic                overrun
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CW    = (LOG_ADDR > 20) ? LOG_ADDR : 20;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  logic             flag_d;
  logic             pending_swap;
  logic             skip;
  logic [LAT_W-1:0] lat_cnt;

  logic             req;
  logic             in_range;
  logic             frame_start;
  logic             swap_now;
  logic             bank_eff;
  logic [CW-1:0]    vcount_w;
  logic [CW-1:0]    word_addr;
  logic [CW-1:0]    full_addr;

  assign req         = vga_flag & ~flag_d;
  assign in_range    = (clocked_hcount < HACTIVE[9:0]) && (clocked_vcount < VACTIVE[9:0]);
  assign frame_start = (clocked_vcount == 10'd0) && (clocked_hcount[9:1] == 9'd0);
  // A swap requested in the same cycle as the frame-start request still applies to that request.
  assign swap_now    = req && (state == IDLE) && frame_start && (pending_swap || frame_flag);
  assign bank_eff    = disp_bank ^ swap_now;

  assign vcount_w  = {{(CW-10){1'b0}}, clocked_vcount};
  assign word_addr = (vcount_w << 8) + (vcount_w << 6) + {{(CW-9){1'b0}}, clocked_hcount[9:1]};
  assign full_addr = word_addr + (bank_eff ? CW'(BANK1_BASE) : '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      flag_d       <= 1'b0;
      pending_swap <= 1'b0;
      skip         <= 1'b0;
      lat_cnt      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      vga_pixel    <= '0;
      done_vga     <= 1'b0;
      disp_bank    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      flag_d   <= vga_flag;
      done_vga <= 1'b0;

      if (swap_now) begin
        disp_bank    <= bank_eff;
        pending_swap <= 1'b0;
      end else if (frame_flag) begin
        pending_swap <= 1'b1;
      end

      if (req && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req) begin
            if (in_range) begin
              mem.mem_addr <= full_addr[LOG_ADDR-1:0];
              mem.mem_req  <= 1'b1;
              skip         <= 1'b0;
              state        <= ISSUE;
            end else begin
              // Out-of-range requests reuse the WAIT exit so completion goes through one path.
              skip    <= 1'b1;
              lat_cnt <= '0;
              state   <= WAIT;
            end
          end
        end
        ISSUE: begin
          if (mem.mem_grant) begin
            mem.mem_req <= 1'b0;
            lat_cnt     <= LAT_W'(MEM_LAT - 1);
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            vga_pixel <= skip ? 36'd0 : mem.mem_rdata;
            done_vga  <= 1'b1;
            state     <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VGA_FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset || swap_now) begin
      stall_cycles  <= '0;
      overrun_count <= '0;
    end else begin
      if ((state == ISSUE) && !mem.mem_grant && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (req && (state != IDLE) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - directed bench for vga_pixel_fetch
// Statistics checks are compiled in when VGA_FETCH_STATS_EN is defined.
module tb_vga_pixel_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_flag;
  logic        vga_flag;
  logic [9:0]  clocked_hcount;
  logic [9:0]  clocked_vcount;
  logic [35:0] vga_pixel;
  logic        done_vga;
  logic        disp_bank;
  logic        overrun;
`ifdef VGA_FETCH_STATS_EN
  logic [15:0] stall_cycles;
  logic [7:0]  overrun_count;
`endif

  int errors = 0;
  int checks = 0;

  vga_pixel_fetch_if #(.LOG_ADDR(19)) mem_if ();

  vga_pixel_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .frame_flag     (frame_flag),
    .vga_flag       (vga_flag),
    .clocked_hcount (clocked_hcount),
    .clocked_vcount (clocked_vcount),
    .mem            (mem_if.master),
    .vga_pixel      (vga_pixel),
    .done_vga       (done_vga),
    .disp_bank      (disp_bank),
`ifdef VGA_FETCH_STATS_EN
    .stall_cycles   (stall_cycles),
    .overrun_count  (overrun_count),
`endif
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic issue_req(input logic [9:0] h, input logic [9:0] v);
    clocked_hcount = h;
    clocked_vcount = v;
    vga_flag       = 1'b1;
    tick();
    vga_flag       = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    frame_flag       = 1'b0;
    vga_flag         = 1'b0;
    clocked_hcount   = '0;
    clocked_vcount   = '0;
    mem_if.mem_grant = 1'b1;
    mem_if.mem_rdata = '0;
    tick();
    tick();
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_pixel", vga_pixel, 0);
    check("rst_done", done_vga, 0);
    check("rst_bank", disp_bank, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;
    tick();

    // Basic read, h=5 v=3 -> 3*320+2 = 962
    mem_if.mem_rdata = 36'h111111111;
    issue_req(10'd5, 10'd3);
    check("t1_req", mem_if.mem_req, 1);
    check("t1_addr", mem_if.mem_addr, 962);
    mem_if.mem_rdata = 36'h222222222;
    tick();
    check("t1_req_drop", mem_if.mem_req, 0);
    mem_if.mem_rdata = 36'h333333333;
    tick();
    check("t1_done_early", done_vga, 0);
    mem_if.mem_rdata = 36'h9ABCDEF12;
    tick();
    check("t1_done", done_vga, 1);
    check("t1_pixel", vga_pixel, 36'h9ABCDEF12);
    mem_if.mem_rdata = 36'h444444444;
    tick();
    check("t1_done_pulse", done_vga, 0);
    check("t1_pixel_hold", vga_pixel, 36'h9ABCDEF12);

    // Bank swap at frame start
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    tick();
    check("t2_bank_before", disp_bank, 0);
    check("t2_pending_set", dut.pending_swap, 1);
    issue_req(10'd0, 10'd0);
    check("t2_bank_after", disp_bank, 1);
    check("t2_addr_base", mem_if.mem_addr, 153600);
    check("t2_pending_clr", dut.pending_swap, 0);
    tick();
    tick();
    tick();
    check("t2_done", done_vga, 1);
    tick();
    issue_req(10'd639, 10'd479);
    check("t2_addr_last", mem_if.mem_addr, 307199);
    tick();
    tick();
    tick();
    check("t2_last_done", done_vga, 1);
    tick();
    issue_req(10'd1, 10'd0);
    check("t2_no_reswap", disp_bank, 1);
    check("t2_addr_again", mem_if.mem_addr, 153600);
    tick();
    tick();
    tick();
    tick();

    // frame_flag coinciding with the frame-start request swaps immediately
    frame_flag = 1'b1;
    issue_req(10'd0, 10'd0);
    frame_flag = 1'b0;
    check("t2b_bank", disp_bank, 0);
    check("t2b_addr", mem_if.mem_addr, 0);
    check("t2b_pending", dut.pending_swap, 0);
    tick();
    tick();
    tick();
    tick();

    // Out-of-range requests
    mem_if.mem_rdata = 36'h777777777;
    issue_req(10'd700, 10'd10);
    check("t3_no_req", mem_if.mem_req, 0);
    check("t3_done_early", done_vga, 0);
    tick();
    check("t3_done", done_vga, 1);
    check("t3_pixel", vga_pixel, 0);
    check("t3_no_req2", mem_if.mem_req, 0);
    tick();
    check("t3_done_pulse", done_vga, 0);
    issue_req(10'd0, 10'd480);
    check("t3b_no_req", mem_if.mem_req, 0);
    tick();
    check("t3b_done", done_vga, 1);
    tick();

    // Arbiter stall: five cycles without grant, h=2 v=1 -> 321
    mem_if.mem_grant = 1'b0;
    issue_req(10'd2, 10'd1);
    check("t4_req", mem_if.mem_req, 1);
    check("t4_addr", mem_if.mem_addr, 321);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_req_held", mem_if.mem_req, 1);
      check("t4_addr_held", mem_if.mem_addr, 321);
    end
    mem_if.mem_grant = 1'b1;
    mem_if.mem_rdata = 36'h888888888;
    tick();
    check("t4_req_drop", mem_if.mem_req, 0);
    tick();
    check("t4_done_early", done_vga, 0);
    mem_if.mem_rdata = 36'h0F0F0F0F0;
    tick();
    check("t4_done", done_vga, 1);
    check("t4_pixel", vga_pixel, 36'h0F0F0F0F0);
`ifdef VGA_FETCH_STATS_EN
    check("t4_stall_cycles", stall_cycles, 5);
`endif
    tick();

    // Second request while waiting for data: dropped, overrun set
    mem_if.mem_rdata = 36'h999999999;
    issue_req(10'd10, 10'd20);
    check("t5_addr", mem_if.mem_addr, 6405);
    tick();
    clocked_hcount = 10'd12;
    vga_flag       = 1'b1;
    tick();
    vga_flag       = 1'b0;
    check("t5_overrun", overrun, 1);
    check("t5_done_early", done_vga, 0);
    mem_if.mem_rdata = 36'h123456789;
    tick();
    check("t5_done", done_vga, 1);
    check("t5_pixel", vga_pixel, 36'h123456789);
    mem_if.mem_rdata = 36'hAAAAAAAAA;
    tick();
    check("t5_single_done", done_vga, 0);
    check("t5_no_second_req", mem_if.mem_req, 0);
    tick();
    check("t5_single_done2", done_vga, 0);
    check("t5_no_second_req2", mem_if.mem_req, 0);
`ifdef VGA_FETCH_STATS_EN
    check("t5_overrun_count", overrun_count, 1);
`endif

    // Reset in the middle of a read
    issue_req(10'd4, 10'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_req_rst", mem_if.mem_req, 0);
    check("t6_done_rst", done_vga, 0);
    tick();
    check("t6_done_rst2", done_vga, 0);
    reset = 1'b1;
    tick();
    check("t6_done_after", done_vga, 0);
    check("t6_overrun_clr", overrun, 0);
    mem_if.mem_rdata = 36'hBBBBBBBBB;
    issue_req(10'd6, 10'd2);
    check("t6_addr", mem_if.mem_addr, 643);
    tick();
    tick();
    mem_if.mem_rdata = 36'h55AA55AA5;
    tick();
    check("t6_done", done_vga, 1);
    check("t6_pixel", vga_pixel, 36'h55AA55AA5);
    tick();
    check("t6_done_pulse", done_vga, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
